// File: rtl/timer_bank.sv
// timer_bank: memory-mapped bank of NUM_CH interval timers.
//
// Each channel has a reload value (TH), a counter (TL), a control register
// (TCON: EN, IE, PEND mirror, MODE) and an optional clock prescaler (PRESC).
// Overflow interrupts collect in a global write-1-to-clear PEND register.
// irqout is masked while the CPU runs in kernel mode (PC_31 = 1).
//
// Build option: define TIMER_BANK_PRESCALER_EN to include the PRESC
// registers and PCNT counters. When undefined, channels tick every cycle
// while enabled and PRESC offsets read 0 and ignore writes.
//
// Ports:
//   sysclk  - clock, all state updates on its rising edge
//   reset   - synchronous active-low reset
//   rd, wr  - bus read / write strobes
//   addr    - byte address (exact word match)
//   wdata   - write data
//   rdata   - combinational read data (0 when not reading a mapped register)
//   PC_31   - CPU kernel-mode bit, masks irqout
//   irqout  - aggregated interrupt request
//   ovf     - registered one-cycle overflow pulse per channel
//
// Register map (c = channel, stride 16): +0 TH, +4 TL, +8 TCON, +C PRESC;
// BASE+0x80 PEND.

module timer_bank #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned PRESC_W   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0100
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic              PC_31,
  output logic              irqout,
  output logic [NUM_CH-1:0] ovf
);

  // Address decode
  logic       blk_hit;
  logic       chan_area;
  logic       pend_hit;
  logic [2:0] ch_idx;
  logic [1:0] reg_sel;

  assign blk_hit   = (addr[31:8] == BASE_ADDR[31:8]) & (addr[1:0] == 2'b00);
  assign chan_area = blk_hit & ~addr[7];
  assign pend_hit  = blk_hit & (addr[7:2] == 6'h20);
  assign ch_idx    = addr[6:4];
  assign reg_sel   = addr[3:2];

  logic [NUM_CH-1:0]       pend_q;
  logic [NUM_CH-1:0]       ovf_q;
  logic [NUM_CH-1:0]       ovf_now;
  logic [NUM_CH-1:0]       pend_set;
  logic [NUM_CH-1:0]       pend_clr;
  logic [NUM_CH-1:0][31:0] chan_rd;

  // Upper write-data bits are unused for narrow counters.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] th_q;
    logic [CNT_W-1:0] tl_q;
    logic             en_q;
    logic             ie_q;
    logic             mode_q;
    logic             sel;
    logic             wr_th;
    logic             wr_tl;
    logic             wr_tcon;
    logic             tick;
    logic             eff_tick;
    logic             tl_max;
    logic [31:0]      tcon_rd;
    logic [31:0]      presc_rd;

    assign sel     = chan_area & (ch_idx == 3'(c));
    assign wr_th   = wr & sel & (reg_sel == 2'd0);
    assign wr_tl   = wr & sel & (reg_sel == 2'd1);
    assign wr_tcon = wr & sel & (reg_sel == 2'd2);

`ifdef TIMER_BANK_PRESCALER_EN
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] pcnt_q;
    logic               wr_presc;
    logic               en_rise;

    assign wr_presc = wr & sel & (reg_sel == 2'd3);
    assign en_rise  = wr_tcon & wdata[0] & ~en_q;
    assign tick     = en_q & (pcnt_q == presc_q);
    assign presc_rd = 32'(presc_q);

    // PCNT keeps advancing even when a bus write discards the tick.
    always_ff @(posedge sysclk) begin
      if (!reset) begin
        presc_q <= '0;
        pcnt_q  <= '0;
      end else begin
        if (wr_presc) presc_q <= wdata[PRESC_W-1:0];
        if (en_rise) begin
          pcnt_q <= '0;
        end else if (en_q) begin
          pcnt_q <= tick ? '0 : pcnt_q + 1'b1;
        end
      end
    end
`else
    logic [PRESC_W-1:0] unused_presc;
    assign unused_presc = '0;
    assign tick         = en_q;
    assign presc_rd     = '0;
`endif

    // A bus write to TH or TL swallows a coincident tick.
    assign eff_tick    = tick & ~wr_th & ~wr_tl;
    assign tl_max      = &tl_q;
    assign ovf_now[c]  = eff_tick & tl_max;
    assign pend_set[c] = ovf_now[c] & ie_q;

    always_ff @(posedge sysclk) begin
      if (!reset) begin
        th_q   <= '0;
        tl_q   <= '0;
        en_q   <= 1'b0;
        ie_q   <= 1'b0;
        mode_q <= 1'b0;
      end else begin
        if (wr_th) th_q <= wdata[CNT_W-1:0];
        if (wr_tl) begin
          tl_q <= wdata[CNT_W-1:0];
        end else if (eff_tick) begin
          tl_q <= tl_max ? th_q : tl_q + 1'b1;
        end
        if (wr_tcon) begin
          en_q   <= wdata[0];
          ie_q   <= wdata[1];
          mode_q <= wdata[3];
        end else if (ovf_now[c] && mode_q) begin
          en_q <= 1'b0;
        end
      end
    end

    assign tcon_rd = {28'b0, mode_q, pend_q[c], ie_q, en_q};

    assign chan_rd[c] = !(rd && sel)       ? 32'h0 :
                        (reg_sel == 2'd0) ? 32'(th_q) :
                        (reg_sel == 2'd1) ? 32'(tl_q) :
                        (reg_sel == 2'd2) ? tcon_rd : presc_rd;
  end

  assign pend_clr = (wr && pend_hit) ? wdata[NUM_CH-1:0] : '0;

  // Overflow set wins over a coincident write-1-clear.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      pend_q <= (pend_q & ~pend_clr) | pend_set;
      ovf_q  <= ovf_now;
    end
  end

  always_comb begin
    rdata = (rd && pend_hit) ? 32'(pend_q) : 32'h0;
    for (int i = 0; i < NUM_CH; i++) begin
      rdata = rdata | chan_rd[i];
    end
  end

  assign irqout = ~PC_31 & (|pend_q);
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;

  localparam logic [31:0] Base = 32'h4000_0100;
  localparam logic [31:0] Pend = Base + 32'h80;
`ifdef TIMER_BANK_PRESCALER_EN
  localparam int          Lat      = 4;
  localparam logic [31:0] PrescExp = 32'h3;
`else
  localparam int          Lat      = 1;
  localparam logic [31:0] PrescExp = 32'h0;
`endif

  logic        sysclk = 1'b0;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        PC_31;
  logic        irqout;
  logic [3:0]  ovf;

  int passed = 0;
  int total  = 0;

  timer_bank #(
    .NUM_CH   (4),
    .CNT_W    (32),
    .PRESC_W  (8),
    .BASE_ADDR(Base)
  ) dut (
    .sysclk(sysclk),
    .reset (reset),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .PC_31 (PC_31),
    .irqout(irqout),
    .ovf   (ovf)
  );

  always #50 sysclk = ~sysclk;

  function automatic logic [31:0] ra(input int ch, input int r);
    return Base + 32'(16 * ch) + 32'(4 * r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(posedge sysclk);
    #1;
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    rd = 1'b1; addr = a;
    #1;
    chk(tag, rdata, exp);
    rd = 1'b0; addr = '0;
  endtask

  initial begin
    // Reset held for two edges while a TH write is attempted
    reset = 1'b0; rd = 1'b0; wr = 1'b1; addr = ra(0, 0); wdata = 32'h1234; PC_31 = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    reset = 1'b1; wr = 1'b0; addr = '0; wdata = '0;
    rd_chk("rst_th0", ra(0, 0), 32'h0);
    rd_chk("rst_tl0", ra(0, 1), 32'h0);
    rd_chk("rst_tcon0", ra(0, 2), 32'h0);
    rd_chk("rst_presc0", ra(0, 3), 32'h0);
    rd_chk("rst_th3", ra(3, 0), 32'h0);
    rd_chk("rst_pend", Pend, 32'h0);
    chk("rst_irq", 32'(irqout), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);

    // Auto-reload on channel 0, period 3
    bus_write(ra(0, 0), 32'hFFFF_FFFD);
    bus_write(ra(0, 1), 32'hFFFF_FFFD);
    bus_write(ra(0, 2), 32'h3);
    rd_chk("ar_tl_start", ra(0, 1), 32'hFFFF_FFFD);
    step();
    rd_chk("ar_tl_1", ra(0, 1), 32'hFFFF_FFFE);
    chk("ar_ovf_1", 32'(ovf), 32'h0);
    step();
    rd_chk("ar_tl_2", ra(0, 1), 32'hFFFF_FFFF);
    chk("ar_irq_2", 32'(irqout), 32'h0);
    step();
    rd_chk("ar_tl_3", ra(0, 1), 32'hFFFF_FFFD);
    chk("ar_ovf_3", 32'(ovf), 32'h1);
    rd_chk("ar_pend_3", Pend, 32'h1);
    rd_chk("ar_tcon_3", ra(0, 2), 32'h7);
    chk("ar_irq_user", 32'(irqout), 32'h1);
    PC_31 = 1'b1;
    #1;
    chk("ar_irq_kernel", 32'(irqout), 32'h0);
    PC_31 = 1'b0;
    step();
    chk("ar_ovf_pulse", 32'(ovf), 32'h0);
    rd_chk("ar_tl_4", ra(0, 1), 32'hFFFF_FFFE);
    step();
    step();
    chk("ar_ovf_6", 32'(ovf), 32'h1);
    rd_chk("ar_tl_6", ra(0, 1), 32'hFFFF_FFFD);

    // PEND write-1-clear and collision with an overflow
    bus_write(Pend, 32'h1);
    rd_chk("pc_clr", Pend, 32'h0);
    chk("pc_irq_clr", 32'(irqout), 32'h0);
    step();
    bus_write(Pend, 32'h1);
    chk("pc_coll_ovf", 32'(ovf), 32'h1);
    rd_chk("pc_coll_pend", Pend, 32'h1);
    bus_write(Pend, 32'h1);
    rd_chk("pc_clr2", Pend, 32'h0);
    chk("pc_irq_drop", 32'(irqout), 32'h0);
    bus_write(ra(0, 2), 32'h0);
    step();
    rd_chk("stop_tl0", ra(0, 1), 32'hFFFF_FFFF);
    chk("stop_ovf", 32'(ovf), 32'h0);

    // Bus write to TL / TH wins over a coincident tick (channel 2)
    bus_write(ra(2, 2), 32'h1);
    bus_write(ra(2, 1), 32'h10);
    rd_chk("wp_tl_wr", ra(2, 1), 32'h10);
    step();
    rd_chk("wp_tl_inc", ra(2, 1), 32'h11);
    bus_write(ra(2, 0), 32'h5);
    rd_chk("wp_tl_thwr", ra(2, 1), 32'h11);
    rd_chk("wp_th", ra(2, 0), 32'h5);
    step();
    rd_chk("wp_tl_inc2", ra(2, 1), 32'h12);
    bus_write(ra(2, 2), 32'h0);

    // One-shot with prescaler on channel 1
    bus_write(ra(1, 3), 32'h3);
    rd_chk("ps_presc", ra(1, 3), PrescExp);
    bus_write(ra(1, 0), 32'hABCD);
    bus_write(ra(1, 1), 32'hFFFF_FFFF);
    bus_write(ra(1, 2), 32'h9);
    rd_chk("ps_tl_0", ra(1, 1), 32'hFFFF_FFFF);
    for (int i = 1; i < Lat; i++) begin
      step();
      rd_chk("ps_tl_wait", ra(1, 1), 32'hFFFF_FFFF);
      chk("ps_ovf_wait", 32'(ovf), 32'h0);
    end
    step();
    rd_chk("ps_tl_reload", ra(1, 1), 32'hABCD);
    chk("ps_ovf", 32'(ovf), 32'h2);
    rd_chk("ps_tcon", ra(1, 2), 32'h8);
    rd_chk("ps_pend", Pend, 32'h0);
    step();
    chk("ps_ovf_once", 32'(ovf), 32'h0);
    rd_chk("ps_tl_hold", ra(1, 1), 32'hABCD);

    // Decode: unmapped slots and offsets
    rd_chk("dec_slot4", Base + 32'h40, 32'h0);
    rd_chk("dec_84", Base + 32'h84, 32'h0);
    bus_write(Base + 32'h40, 32'hFFFF_FFFF);
    bus_write(Base + 32'h84, 32'hFFFF_FFFF);
    bus_write(Base + 32'h100, 32'h55);
    rd_chk("dec_th0", ra(0, 0), 32'hFFFF_FFFD);
    rd_chk("dec_th3", ra(3, 0), 32'h0);
    rd_chk("dec_tcon3", ra(3, 2), 32'h0);
    rd_chk("dec_pend", Pend, 32'h0);
    addr = ra(0, 0);
    rd = 1'b0;
    #1;
    chk("dec_rd0", rdata, 32'h0);
    addr = '0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
